// File: rtl/elevator_scheduler_if.sv
// Button inputs and car status outputs of the three-floor elevator scheduler.
// The master side presses buttons and watches status; the slave side is the scheduler.
interface elevator_scheduler_if;
   logic       button1;
   logic       button2;
   logic       button3;
   logic       moving;
   logic       direction;
   logic       door_open;
   logic [1:0] floor;
   logic [2:0] pending;

   modport master (
      output button1, button2, button3,
      input  moving, direction, door_open, floor, pending
   );

   modport slave (
      input  button1, button2, button3,
      output moving, direction, door_open, floor, pending
   );
endinterface

// File: rtl/elevator_scheduler.sv
// Three-floor elevator controller: latches active-low button presses and
// serves them with a keep-direction (SCAN) policy, timing travel and door dwell in clock cycles.
module elevator_scheduler #(
   parameter int TRAVEL_CYCLES = 100,
   parameter int DOOR_CYCLES   = 50
) (
   input logic                 clk_50,
   input logic                 rst_n,
   elevator_scheduler_if.slave bus
);

   localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES);
   localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_CYCLES - 1);
   localparam logic [CW-1:0] DOOR_LAST   = CW'(DOOR_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MOVE = 2'd1,
      ST_DOOR = 2'd2
   } state_t;

   function automatic logic [2:0] floor_mask(input logic [1:0] f);
      case (f)
         2'd0:    floor_mask = 3'b001;
         2'd1:    floor_mask = 3'b010;
         2'd2:    floor_mask = 3'b100;
         default: floor_mask = 3'b000;
      endcase
   endfunction

   function automatic logic [2:0] above_mask(input logic [1:0] f);
      case (f)
         2'd0:    above_mask = 3'b110;
         2'd1:    above_mask = 3'b100;
         default: above_mask = 3'b000;
      endcase
   endfunction

   function automatic logic [2:0] below_mask(input logic [1:0] f);
      case (f)
         2'd1:    below_mask = 3'b001;
         2'd2:    below_mask = 3'b011;
         default: below_mask = 3'b000;
      endcase
   endfunction

   logic [2:0]    sync1_r, sync2_r, hist_r;
   state_t        state_r;
   logic [1:0]    floor_r;
   logic          direction_r, moving_r, door_open_r;
   logic [2:0]    pending_r;
   logic [CW-1:0] cnt_r;

   logic [2:0] btn_s, press_s, here_s, set_s, clr_s;
   logic [1:0] next_floor_s;
   logic       arrive_s, hit_s, door_press_s, any_above_s, any_below_s;

   assign btn_s        = {bus.button3, bus.button2, bus.button1};
   assign press_s      = hist_r & ~sync2_r;
   assign here_s       = floor_mask(floor_r);
   assign arrive_s     = (state_r == ST_MOVE) && (cnt_r == TRAVEL_LAST);
   assign hit_s        = |(pending_r & floor_mask(next_floor_s));
   assign door_press_s = (state_r == ST_DOOR) && (|(press_s & here_s));
   // The door's own floor is never latched while the door is open; that press only extends dwell.
   assign set_s        = (state_r == ST_DOOR) ? (press_s & ~here_s) : press_s;
   assign any_above_s  = |(pending_r & above_mask(floor_r));
   assign any_below_s  = |(pending_r & below_mask(floor_r));

   // Floor reached at the end of the current travel leg, clamped to the shaft ends.
   always_comb begin
      next_floor_s = floor_r;
      if (direction_r) begin
         next_floor_s = (floor_r == 2'd2) ? 2'd2 : floor_r + 2'd1;
      end else begin
         next_floor_s = (floor_r == 2'd0) ? 2'd0 : floor_r - 2'd1;
      end
   end

   // Pending bit being served on this edge.
   always_comb begin
      clr_s = 3'b000;
      case (state_r)
         ST_IDLE: clr_s = pending_r & here_s;
         ST_MOVE: begin
            if (arrive_s) begin
               clr_s = pending_r & floor_mask(next_floor_s);
            end else begin
               clr_s = 3'b000;
            end
         end
         default: clr_s = 3'b000;
      endcase
   end

   // Two-flop synchronizer plus history flop per button; idle level is high.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 3'b111;
         sync2_r <= 3'b111;
         hist_r  <= 3'b111;
      end else begin
         sync1_r <= btn_s;
         sync2_r <= sync1_r;
         hist_r  <= sync2_r;
      end
   end

   // Scheduler state machine with registered status outputs and request latch.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         floor_r     <= 2'd0;
         direction_r <= 1'b1;
         moving_r    <= 1'b0;
         door_open_r <= 1'b0;
         pending_r   <= 3'b000;
         cnt_r       <= {CW{1'b0}};
      end else begin
         pending_r <= (pending_r & ~clr_s) | set_s;
         case (state_r)
            ST_IDLE: begin
               cnt_r <= {CW{1'b0}};
               if (|(pending_r & here_s)) begin
                  state_r     <= ST_DOOR;
                  door_open_r <= 1'b1;
               end else if (any_above_s || any_below_s) begin
                  state_r  <= ST_MOVE;
                  moving_r <= 1'b1;
                  if (!any_below_s) begin
                     direction_r <= 1'b1;
                  end else if (!any_above_s) begin
                     direction_r <= 1'b0;
                  end else begin
                     direction_r <= direction_r;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_MOVE: begin
               if (arrive_s) begin
                  floor_r <= next_floor_s;
                  cnt_r   <= {CW{1'b0}};
                  if (hit_s) begin
                     state_r     <= ST_DOOR;
                     moving_r    <= 1'b0;
                     door_open_r <= 1'b1;
                  end else if ((direction_r && next_floor_s == 2'd2) ||
                               (!direction_r && next_floor_s == 2'd0)) begin
                     state_r  <= ST_IDLE;
                     moving_r <= 1'b0;
                  end else begin
                     state_r <= ST_MOVE;
                  end
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            ST_DOOR: begin
               if (door_press_s) begin
                  cnt_r <= {CW{1'b0}};
               end else if (cnt_r == DOOR_LAST) begin
                  state_r     <= ST_IDLE;
                  door_open_r <= 1'b0;
                  cnt_r       <= {CW{1'b0}};
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               moving_r    <= 1'b0;
               door_open_r <= 1'b0;
               cnt_r       <= {CW{1'b0}};
            end
         endcase
      end
   end

   assign bus.floor     = floor_r;
   assign bus.direction = direction_r;
   assign bus.moving    = moving_r;
   assign bus.door_open = door_open_r;
   assign bus.pending   = pending_r;

endmodule
